// File: rtl/vital_scan_sequencer.sv
// Round-robin sensor scanner: per channel it starts the settle timer, samples on done, range-checks, and raises sticky alarms.
// Optional MON_TIMEOUT_EN adds a WAIT_DONE watchdog of TO_CYC cycles that flags tmr_err and forces the sample.
module vital_scan_sequencer #(
  parameter int NCH    = 4,
  parameter int CW     = 2,
  parameter int DW     = 8,
  parameter int VIOL_N = 3,
  parameter int TO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              alarm_ack,
  input  logic [DW-1:0]     sensor_data,
  input  logic [NCH*DW-1:0] lo_thr,
  input  logic [NCH*DW-1:0] hi_thr,
  input  logic              tmr_done,
  output logic              tmr_start,
  output logic [CW-1:0]     ch_sel,
  output logic              sample_valid,
  output logic [CW-1:0]     sample_ch,
  output logic [DW-1:0]     sample_data,
  output logic [NCH-1:0]    alarm,
  output logic              busy,
  output logic              tmr_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_SAMPLE    = 3'd4;
  localparam logic [2:0] S_NEXT      = 3'd5;

  logic [2:0]    state;
  logic [3:0]    cnt [NCH];
  logic [3:0]    cnt_cur;
  logic [3:0]    cnt_upd;
  logic [DW-1:0] lo_cur;
  logic [DW-1:0] hi_cur;
  logic          viol_cur;
  logic          alarm_set;

  function automatic logic out_of_range(input logic [DW-1:0] d, input logic [DW-1:0] lo,
                                        input logic [DW-1:0] hi);
    return (d < lo) || (d > hi);
  endfunction

  // Consecutive-violation count, saturating at VIOL_N; any in-range sample restarts it.
  function automatic logic [3:0] cnt_next(input logic [3:0] c, input logic v);
    if (!v)
      return 4'd0;
    if (c >= 4'(VIOL_N))
      return 4'(VIOL_N);
    return c + 4'd1;
  endfunction

  assign tmr_start    = (state == S_START);
  assign sample_valid = (state == S_NEXT);
  assign busy         = (state != S_IDLE);

  assign lo_cur    = lo_thr[int'(ch_sel)*DW +: DW];
  assign hi_cur    = hi_thr[int'(ch_sel)*DW +: DW];
  assign viol_cur  = out_of_range(sensor_data, lo_cur, hi_cur);
  assign cnt_upd   = cnt_next(cnt_cur, viol_cur);
  assign alarm_set = (cnt_upd >= 4'(VIOL_N));

  always_comb begin
    cnt_cur = 4'd0;
    for (int i = 0; i < NCH; i++)
      if (ch_sel == CW'(i))
        cnt_cur = cnt[i];
  end

`ifdef MON_TIMEOUT_EN
  localparam int TW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tmo_cnt <= '0;
    else if (state == S_WAIT_DONE)
      tmo_cnt <= tmo_cnt + 1'b1;
    else
      tmo_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ch_sel  <= '0;
      tmr_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE:      if (en) state <= S_START;
        S_START:     state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          // A timer still reporting done right after a start has ignored it.
          if (tmr_done) begin
            tmr_err <= 1'b1;
            state   <= S_SAMPLE;
          end else begin
            state   <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (tmr_done)
            state <= S_SAMPLE;
`ifdef MON_TIMEOUT_EN
          else if (tmo_cnt == TW'(TO_CYC - 1)) begin
            tmr_err <= 1'b1;
            state   <= S_SAMPLE;
          end
`endif
        end
        S_SAMPLE:    state <= S_NEXT;
        S_NEXT: begin
          ch_sel <= (ch_sel == CW'(NCH - 1)) ? '0 : ch_sel + 1'b1;
          state  <= en ? S_START : S_IDLE;
        end
        default:     state <= S_IDLE;
      endcase
    end
  end

  // Sample capture, violation counting and alarm latching share the edge leaving SAMPLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_data <= '0;
      sample_ch   <= '0;
      alarm       <= '0;
      for (int i = 0; i < NCH; i++)
        cnt[i] <= 4'd0;
    end else begin
      if (state == S_SAMPLE) begin
        sample_data <= sensor_data;
        sample_ch   <= ch_sel;
      end
      for (int i = 0; i < NCH; i++) begin
        if ((state == S_SAMPLE) && (ch_sel == CW'(i)))
          cnt[i] <= cnt_upd;
        if ((state == S_SAMPLE) && (ch_sel == CW'(i)) && alarm_set)
          alarm[i] <= 1'b1;
        else if (alarm_ack)
          alarm[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vital_scan_sequencer.sv
// Scoreboard bench for vital_scan_sequencer: directed scans against a simple settle-timer model.
module tb_vital_scan_sequencer;

  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int DW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              alarm_ack;
  logic [DW-1:0]     sensor_data;
  logic [NCH*DW-1:0] lo_thr;
  logic [NCH*DW-1:0] hi_thr;
  logic              tmr_done;
  logic              tmr_start;
  logic [CW-1:0]     ch_sel;
  logic              sample_valid;
  logic [CW-1:0]     sample_ch;
  logic [DW-1:0]     sample_data;
  logic [NCH-1:0]    alarm;
  logic              busy;
  logic              tmr_err;

  logic [DW-1:0] sens [NCH];
  logic [7:0]    tcnt = 8'd0;
  logic [7:0]    tm   = 8'd4;
  logic          force_done = 1'b0;
  logic          force_low  = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int cyc = 0;
  int last_start = 0;
  bit have_last = 1'b0;
  bit chk_period = 1'b0;
  int exp_period = 7;

  typedef struct packed {
    logic [CW-1:0]  ch;
    logic [DW-1:0]  data;
    logic [NCH-1:0] alarm;
  } exp_t;
  exp_t q[$];

  vital_scan_sequencer #(.NCH(NCH), .CW(CW), .DW(DW), .VIOL_N(3), .TO_CYC(10)) dut (
    .clk(clk), .rst(rst), .en(en), .alarm_ack(alarm_ack), .sensor_data(sensor_data),
    .lo_thr(lo_thr), .hi_thr(hi_thr), .tmr_done(tmr_done), .tmr_start(tmr_start),
    .ch_sel(ch_sel), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .alarm(alarm), .busy(busy), .tmr_err(tmr_err)
  );

  always #5 clk = ~clk;

  assign sensor_data = sens[ch_sel];
  assign lo_thr      = {NCH{8'd50}};
  assign hi_thr      = {NCH{8'd120}};
  assign tmr_done    = force_done | (!force_low && (tcnt == 8'd0));

  // Timer model: done drops for tm-1 cycles after a start pulse.
  always @(posedge clk) begin
    if (tmr_start)
      tcnt <= tm - 8'd1;
    else if (tcnt != 8'd0)
      tcnt <= tcnt - 8'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int ch, input int data, input int al);
    exp_t e;
    e.ch    = CW'(ch);
    e.data  = DW'(data);
    e.alarm = NCH'(al);
    q.push_back(e);
  endtask

  task automatic wait_valid(input bit stop);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sample_valid && k < 300);
    if (!sample_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL sample_wait: got no sample_valid, expected one within 300 cycles");
    end
    if (stop)
      en = 1'b0;
  endtask

  task automatic do_samples(input int n);
    en = 1'b1;
    for (int i = 0; i < n; i++)
      wait_valid(i == n - 1);
  endtask

  task automatic round(input int v1, input int a1, input int arest);
    sens[1] = DW'(v1);
    push(1, v1, a1);
    push(2, 80, arest);
    push(3, 80, arest);
    push(0, 80, arest);
    do_samples(4);
  endtask

  // Monitor: pops the scoreboard on every sample strobe and tracks start spacing.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (tmr_start) begin
        n_start++;
        if (chk_period && have_last)
          chk("start_period", 32'(cyc - last_start), 32'(exp_period));
        last_start = cyc;
        have_last  = 1'b1;
      end
      if (sample_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_sample: got ch %0d data %0d, expected no sample", sample_ch, sample_data);
        end else begin
          e = q.pop_front();
          chk("sample_ch", 32'(sample_ch), 32'(e.ch));
          chk("sample_data", 32'(sample_data), 32'(e.data));
          chk("alarm_at_sample", 32'(alarm), 32'(e.alarm));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b0;
    en = 1'b0;
    alarm_ack = 1'b0;
    for (int i = 0; i < NCH; i++)
      sens[i] = 8'd80;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmr_start", 32'(tmr_start), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_sample_data", 32'(sample_data), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_starts", 32'(n_start), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(sample_valid), 32'd0);
    chk("idle_tmr_err", 32'(tmr_err), 32'd0);
    chk("idle_ch_sel", 32'(ch_sel), 32'd0);

    // Scan order and 7-cycle period with M=4
    have_last = 1'b0; chk_period = 1'b1; exp_period = 7;
    push(0, 80, 0); push(1, 80, 0); push(2, 80, 0); push(3, 80, 0); push(0, 80, 0);
    do_samples(5);
    chk_period = 1'b0;
    repeat (2) @(negedge clk);
    chk("scan_stop_busy", 32'(busy), 32'd0);
    chk("scan_ch_sel", 32'(ch_sel), 32'd1);
    chk("scan_tmr_err", 32'(tmr_err), 32'd0);

    // Alarm threshold: ch2 above hi; limit values 50 and 120 are in range
    sens[0] = 8'd120; sens[1] = 8'd50; sens[2] = 8'd130; sens[3] = 8'd80;
    push(1, 50, 0); push(2, 130, 0); push(3, 80, 0); push(0, 120, 0);
    push(1, 50, 0); push(2, 130, 0); push(3, 80, 0); push(0, 120, 0);
    push(1, 50, 0); push(2, 130, 4); push(3, 80, 4); push(0, 120, 4);
    do_samples(12);
    for (int i = 0; i < NCH; i++)
      sens[i] = 8'd80;
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    chk("ack_clears", 32'(alarm), 32'd0);

    // Counter restart, ack and re-alarm on ch1
    round(20, 0, 0);
    round(20, 0, 0);
    round(60, 0, 0);
    round(20, 0, 0);
    round(20, 0, 0);
    round(20, 2, 2);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    chk("ack_clears_ch1", 32'(alarm), 32'd0);
    round(20, 2, 2);
    alarm_ack = 1'b1;
    round(20, 2, 0);
    alarm_ack = 1'b0;
    sens[1] = 8'd80;

    // Timer ignores start: sticky tmr_err, 4-cycle period
    force_done = 1'b1;
    have_last = 1'b0; chk_period = 1'b1; exp_period = 4;
    push(1, 80, 0); push(2, 80, 0); push(3, 80, 0); push(0, 80, 0);
    do_samples(4);
    chk_period = 1'b0;
    force_done = 1'b0;
    chk("hs_tmr_err", 32'(tmr_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("hs_tmr_err_sticky", 32'(tmr_err), 32'd1);

    // Drop en during WAIT_DONE of ch1
    tm = 8'd10;
    push(1, 80, 0);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("stop_busy_mid", 32'(busy), 32'd1);
    en = 1'b0;
    wait_valid(1'b0);
    @(negedge clk);
    chk("stop_ch_sel", 32'(ch_sel), 32'd2);
    chk("stop_busy", 32'(busy), 32'd0);

    // Reset during WAIT_DONE aborts without a sample
    en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ch_sel", 32'(ch_sel), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tmr_err", 32'(tmr_err), 32'd0);
    chk("abort_sample_ch", 32'(sample_ch), 32'd0);
    chk("abort_sample_data", 32'(sample_data), 32'd0);
    chk("abort_valid", 32'(sample_valid), 32'd0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);

`ifdef MON_TIMEOUT_EN
    // Timer never finishes: watchdog fires after 10 WAIT_DONE cycles
    force_low = 1'b1;
    push(0, 80, 0);
    en = 1'b1;
    repeat (3) @(negedge clk);
    repeat (9) @(negedge clk);
    chk("tmo_err_before", 32'(tmr_err), 32'd0);
    chk("tmo_still_waiting", 32'(sample_valid), 32'd0);
    @(negedge clk);
    chk("tmo_err_set", 32'(tmr_err), 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("tmo_sample_valid", 32'(sample_valid), 32'd1);
    force_low = 1'b0;
    repeat (2) @(negedge clk);
`endif

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
